// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control slice: FSM state encoding, command codes
// and the prescaler width helper.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_CLR   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_START = 2'd1,
      CMD_STOP  = 2'd2,
      CMD_CLEAR = 2'd3
   } cmd_t;

   // Width of a counter that must hold 0..div-1; never narrower than 1 bit.
   function automatic int unsigned presc_width(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/cmd_debounce.sv
// Command input conditioning: 2-flop synchroniser, stability counter and a one-cycle
// event when a new nonzero code is accepted.
module cmd_debounce
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       evt
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEB_CYCLES);

   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [CW-1:0] cnt;
   logic          stable;

   // sync1 != sync2 means sync2 changes on this edge, so the count restarts with it
   assign stable = (sync1 == sync2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         cnt   <= '0;
         dout  <= '0;
         evt   <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         evt   <= 1'b0;
         if (!stable) begin
            cnt <= '0;
         end else if (cnt != CNT_FULL) begin
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) begin
               dout <= sync2;
               evt  <= (sync2 != dout) && (sync2 != CMD_NONE);
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced commands drive an IDLE/RUN/PAUSE/CLR FSM that
// gates a prescaler producing one-cycle count-enable ticks and a one-cycle clear.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TICK_HZ    = 100,
   parameter int unsigned DEB_CYCLES = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [1:0] cmd_i,
   output logic       tick_o,
   output logic       clr_o,
   output logic       running_o,
   output logic       paused_o,
   output logic [1:0] state_o
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = presc_width(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   logic [1:0]    cmd_acc;
   logic          cmd_evt;
   cmd_t          cmd;
   state_t        state_q;
   state_t        state_n;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_n;
   logic          tick_n;

   cmd_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_deb (
      .clk (clk),
      .rst (rst),
      .din (cmd_i),
      .dout(cmd_acc),
      .evt (cmd_evt)
   );

   assign cmd = cmd_t'(cmd_acc);

   always_comb begin
      state_n = state_q;
      if (cmd_evt && ena) begin
         case (cmd)
            CMD_START: if (state_q == ST_IDLE || state_q == ST_PAUSE) state_n = ST_RUN;
            CMD_STOP:  if (state_q == ST_RUN) state_n = ST_PAUSE;
            CMD_CLEAR: state_n = ST_CLR;
            default:   state_n = state_q;
         endcase
      end
      // CLR always lasts exactly one cycle, whatever command arrives meanwhile
      if (state_q == ST_CLR) state_n = ST_IDLE;
   end

   always_comb begin
      presc_n = presc_q;
      tick_n  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (ena) begin
               if (presc_q == PRESC_LAST) begin
                  presc_n = '0;
                  tick_n  = 1'b1;
               end else begin
                  presc_n = presc_q + PW'(1);
               end
            end
         end
         ST_PAUSE: presc_n = presc_q;
         default:  presc_n = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         tick_o    <= 1'b0;
         clr_o     <= 1'b0;
         running_o <= 1'b0;
         paused_o  <= 1'b0;
      end else begin
         state_q   <= state_n;
         presc_q   <= presc_n;
         tick_o    <= tick_n;
         clr_o     <= (state_n == ST_CLR);
         running_o <= (state_n == ST_RUN);
         paused_o  <= (state_n == ST_PAUSE);
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DEB_CYCLES=3: a timeline table of
// {inputs, hold cycles, expected outputs, expected tick count} plus reset sequences.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [1:0] cmd_i;
   logic       tick_o;
   logic       clr_o;
   logic       running_o;
   logic       paused_o;
   logic [1:0] state_o;

   int unsigned total;
   int unsigned bad;

   stopwatch_ctrl #(
      .CLK_HZ    (100),
      .TICK_HZ   (10),
      .DEB_CYCLES(3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .cmd_i    (cmd_i),
      .tick_o   (tick_o),
      .clr_o    (clr_o),
      .running_o(running_o),
      .paused_o (paused_o),
      .state_o  (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  cmd;
      logic        ena;
      int unsigned n;
      logic [1:0]  st;
      logic        clr;
      logic        tick;
      logic        run;
      logic        pau;
      int unsigned nt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] cmd, input logic en, input int unsigned n,
                               input logic [1:0] st, input logic clr, input logic tick,
                               input logic run, input logic pau, input int unsigned nt);
      vec_t v;
      v.cmd = cmd; v.ena = en; v.n = n; v.st = st; v.clr = clr;
      v.tick = tick; v.run = run; v.pau = pau; v.nt = nt;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] outs();
      return {state_o, clr_o, tick_o, running_o, paused_o};
   endfunction

   task automatic chk_out(input string name, input logic [5:0] exp);
      logic [5:0] got;
      got = outs();
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {st,clr,tick,run,pau}=%b required %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_cnt(input string name, input int unsigned got, input int unsigned exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: tick count got %0d required %0d at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      int unsigned nt;
      total = 0;
      bad   = 0;

      //           cmd   ena   n    st    clr   tick  run   pau   ticks
      tbl.push_back(mk(2'd0, 1'b1, 10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0)); // idle after reset
      tbl.push_back(mk(2'd1, 1'b1, 5,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0)); // START not yet applied
      tbl.push_back(mk(2'd1, 1'b1, 1,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // RUN 6 cycles after change
      tbl.push_back(mk(2'd1, 1'b1, 9,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 1,  2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // first tick at +10
      tbl.push_back(mk(2'd1, 1'b1, 40, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4)); // 5 ticks in 50
      tbl.push_back(mk(2'd1, 1'b1, 9,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd2, 1'b1, 5,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1)); // STOP event at presc=4
      tbl.push_back(mk(2'd2, 1'b1, 1,  2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 0));
      tbl.push_back(mk(2'd2, 1'b1, 40, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 0)); // no ticks paused
      tbl.push_back(mk(2'd1, 1'b1, 6,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // resume
      tbl.push_back(mk(2'd1, 1'b1, 4,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 1,  2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // tick 5 after resume
      tbl.push_back(mk(2'd1, 1'b1, 4,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd3, 1'b1, 5,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // CLEAR lands on a tick
      tbl.push_back(mk(2'd3, 1'b1, 1,  2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1));
      tbl.push_back(mk(2'd3, 1'b1, 1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0)); // CLR lasts one cycle
      tbl.push_back(mk(2'd3, 1'b1, 20, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0)); // held CLEAR no refire
      tbl.push_back(mk(2'd0, 1'b1, 10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 2,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0)); // 2-cycle glitch
      tbl.push_back(mk(2'd0, 1'b1, 15, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 6,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // START after clear
      tbl.push_back(mk(2'd1, 1'b1, 9,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 1,  2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // full DIV again
      tbl.push_back(mk(2'd2, 1'b1, 6,  2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 0)); // pause, presc=6 kept
      tbl.push_back(mk(2'd2, 1'b1, 100,2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 0));
      tbl.push_back(mk(2'd1, 1'b1, 6,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd1, 1'b1, 2,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // presc now 8
      tbl.push_back(mk(2'd2, 1'b0, 20, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0)); // ena=0: frozen, STOP dropped
      tbl.push_back(mk(2'd2, 1'b1, 1,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd2, 1'b1, 1,  2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1)); // continues from 8
      tbl.push_back(mk(2'd2, 1'b1, 8,  2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
      tbl.push_back(mk(2'd2, 1'b1, 2,  2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1));

      // reset asserted with CLEAR on the input
      rst   = 1'b0;
      ena   = 1'b1;
      cmd_i = 2'd3;
      #1 rst = 1'b1;
      #1 chk_out("reset_immediate", 6'b000000);
      repeat (3) step();
      chk_out("reset_held", 6'b000000);
      rst   = 1'b0;
      cmd_i = 2'd0;

      for (int i = 0; i < tbl.size(); i++) begin
         cmd_i = tbl[i].cmd;
         ena   = tbl[i].ena;
         nt    = 0;
         for (int unsigned c = 0; c < tbl[i].n; c++) begin
            step();
            if (tick_o === 1'b1) nt++;
         end
         chk_out($sformatf("vec%0d_out", i),
                 {tbl[i].st, tbl[i].clr, tbl[i].tick, tbl[i].run, tbl[i].pau});
         chk_cnt($sformatf("vec%0d_ticks", i), nt, tbl[i].nt);
      end

      // asynchronous reset in the middle of a tick cycle
      #2 rst = 1'b1;
      #1 chk_out("async_rst", 6'b000000);
      step();
      rst = 1'b0;

      // STOP held across reset release is accepted but ignored in IDLE
      repeat (12) step();
      chk_out("stop_in_idle", 6'b000000);

      // START accepted while disabled is dropped and does not re-fire on enable
      ena   = 1'b0;
      cmd_i = 2'd1;
      repeat (12) step();
      chk_out("start_ena0", 6'b000000);
      ena = 1'b1;
      repeat (8) step();
      chk_out("start_no_refire", 6'b000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
